// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display multiplex scheduler
package display_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } disp_state_t;

    // Default width of one digit value (one hex nibble).
    localparam int DIGIT_W_DEF = 4;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot cycle counter with blank-done and slot-done strobes
//
// Ports:
//   clk           system clock
//   reset_i       synchronous active-high reset
//   run_i         count while high
//   clear_i       force the count back to 0 (wins over run_i)
//   blank_done_o  high on the last blank cycle of a slot (count == BLANK_CYCLES-1)
//   slot_done_o   high on the last cycle of a slot (count == DIV_COUNT-1)
module slot_timer #(
    parameter int DIV_COUNT    = 2000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_i,
    input  logic run_i,
    input  logic clear_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    localparam int CNT_W = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The wrap is an exact compare, so the counter never needs to roll over.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_done_o = run_i && !clear_i && (cnt_q == BLANK_LAST);
    assign slot_done_o  = run_i && !clear_i && (cnt_q == SLOT_LAST);

endmodule

// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - multiplexed seven-segment digit scan scheduler
//
// Time-shares one decoder across NUM_DIGITS common-anode digits. Each slot
// starts with BLANK_CYCLES cycles of all anodes off, then drives its anode
// for the rest of the DIV_COUNT-cycle slot.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   enable      run the scan; low returns to idle with anodes off
//   digits_in   packed digit values, digit 0 in the LSBs
//   hex_sel     registered nibble for the shared decoder
//   anode_n     registered active-low anode enables, at most one low
//   slot_idx    registered current slot index
//   frame_tick  one-cycle pulse on the first blank cycle after a frame wrap
//
// Build option: DISPLAY_LZ_BLANK_EN enables leading-zero suppression.
module display_mux_scheduler
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DIV_COUNT    = 2000,
    parameter int BLANK_CYCLES = 16,
    parameter int DIGIT_W      = DIGIT_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
    output logic [DIGIT_W-1:0]              hex_sel,
    output logic [NUM_DIGITS-1:0]           anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0]   slot_idx,
    output logic                            frame_tick
);

    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF   = '1;

    disp_state_t            state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [DIGIT_W-1:0]     hex_q, hex_d;
    logic [NUM_DIGITS-1:0]  anode_q, anode_d;
    logic                   tick_q, tick_d;
    logic                   lz_q, lz_d;

    logic                   blank_done;
    logic                   slot_done;
    logic [SLOT_W-1:0]      load_slot;
    logic [DIGIT_W-1:0]     load_nibble;
    logic                   load_lz;

    slot_timer #(
        .DIV_COUNT    (DIV_COUNT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk          (clk),
        .reset_i      (reset),
        .run_i        (state_q != IDLE),
        .clear_i      ((state_q == IDLE) || !enable),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    // Slot whose nibble is loaded on the next BLANK entry: slot 0 when
    // starting from idle, otherwise the successor of the current slot.
    always_comb begin
        load_slot = '0;
        if (state_q != IDLE) begin
            load_slot = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
    end

    assign load_nibble = digits_in[int'(load_slot)*DIGIT_W +: DIGIT_W];

`ifdef DISPLAY_LZ_BLANK_EN
    // A slot is a leading zero when it and every more-significant digit are
    // zero; digit 0 always shows. Sampled together with hex_sel.
    assign load_lz = (load_slot != '0) &&
                     ((digits_in >> (int'(load_slot)*DIGIT_W)) == '0);
`else
    assign load_lz = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        hex_d   = hex_q;
        anode_d = anode_q;
        lz_d    = lz_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                anode_d = ALL_OFF;
                slot_d  = '0;
                if (enable) begin
                    state_d = BLANK;
                    hex_d   = load_nibble;
                    lz_d    = load_lz;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    anode_d = ALL_OFF;
                    slot_d  = '0;
                end else if (blank_done) begin
                    state_d = DRIVE;
                    anode_d = lz_q ? ALL_OFF : ~(NUM_DIGITS'(1) << slot_q);
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                    anode_d = ALL_OFF;
                    slot_d  = '0;
                end else if (slot_done) begin
                    state_d = BLANK;
                    anode_d = ALL_OFF;
                    slot_d  = load_slot;
                    hex_d   = load_nibble;
                    lz_d    = load_lz;
                    tick_d  = (slot_q == SLOT_LAST);
                end
            end
            default: begin
                state_d = IDLE;
                anode_d = ALL_OFF;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            hex_q   <= '0;
            anode_q <= ALL_OFF;
            tick_q  <= 1'b0;
            lz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            hex_q   <= hex_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
            lz_q    <= lz_d;
        end
    end

    assign hex_sel    = hex_q;
    assign anode_n    = anode_q;
    assign slot_idx   = slot_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - self-checking bench for display_mux_scheduler
module tb_display_mux_scheduler;

    localparam int N     = 2;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] digits_in = 8'h00;
    logic [3:0] hex_sel;
    logic [1:0] anode_n;
    logic       slot_idx;
    logic       frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_mux_scheduler #(
        .NUM_DIGITS   (N),
        .DIV_COUNT    (DIV),
        .BLANK_CYCLES (BLANK),
        .DIGIT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .hex_sel    (hex_sel),
        .anode_n    (anode_n),
        .slot_idx   (slot_idx),
        .frame_tick (frame_tick)
    );

    // Reference model: position in the scan is a single running cycle count
    // t since the scan started; everything else follows arithmetically.
    bit         m_run = 0;
    int         m_t = 0;
    logic [7:0] m_word = 8'h00;
    logic [3:0] m_hex = 4'h0;
    logic [1:0] m_anode = 2'b11;
    logic       m_slot = 1'b0;
    logic       m_tick = 1'b0;

    always @(posedge clk) begin
        int s, p;
        bit sup;
        if (reset) begin
            m_run = 0;
            m_t   = 0;
            m_hex = 4'h0;
        end else if (!m_run) begin
            if (enable) begin
                m_run  = 1;
                m_t    = 0;
                m_word = digits_in;
            end
        end else if (!enable) begin
            m_run = 0;
        end else begin
            m_t = m_t + 1;
            if (m_t % DIV == 0) m_word = digits_in;
        end
        if (m_run) begin
            s      = (m_t / DIV) % N;
            p      = m_t % DIV;
            m_hex  = 4'((m_word >> (s * 4)) & 8'h0F);
            m_slot = 1'(s);
            m_tick = (m_t > 0) && (m_t % (N * DIV) == 0);
            sup    = 0;
`ifdef DISPLAY_LZ_BLANK_EN
            sup = (s != 0) && ((m_word >> (s * 4)) == 8'h00);
`endif
            m_anode = (p >= BLANK && !sup) ? ~(2'(1) << s) : 2'b11;
        end else begin
            m_anode = 2'b11;
            m_slot  = 1'b0;
            m_tick  = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [7:0] d);
        reset = 1'b1; enable = 1'b0; step();
        reset = 1'b0; enable = 1'b1; digits_in = d; step();
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] dig;
        logic [1:0] anode;
        logic [3:0] hex;
        logic       slot;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] d,
                       input logic [1:0] a, input logic [3:0] h,
                       input logic s, input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.dig = d; v.anode = a; v.hex = h; v.slot = s; v.tick = t;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] prev_hex;
        logic [1:0] prev_anode;

        // Reset held 3 cycles with enable high, then one full frame plus wrap.
        for (int i = 0; i < 3; i++) add(1, 1, 8'h5A, 2'b11, 4'h0, 0, 0);
        for (int c = 1; c <= 18; c++) begin
            if (c <= 2)       add(0, 1, 8'h5A, 2'b11, 4'hA, 0, 0);
            else if (c <= 8)  add(0, 1, 8'h5A, 2'b10, 4'hA, 0, 0);
            else if (c <= 10) add(0, 1, 8'h5A, 2'b11, 4'h5, 1, 0);
            else if (c <= 16) add(0, 1, 8'h5A, 2'b01, 4'h5, 1, 0);
            else              add(0, 1, 8'h5A, 2'b11, 4'hA, 0, (c == 17));
        end
        foreach (vecs[i]) begin
            reset = vecs[i].rst; enable = vecs[i].en; digits_in = vecs[i].dig;
            step();
            chk($sformatf("vec%0d.anode", i), 32'(anode_n),    32'(vecs[i].anode));
            chk($sformatf("vec%0d.hex",   i), 32'(hex_sel),    32'(vecs[i].hex));
            chk($sformatf("vec%0d.slot",  i), 32'(slot_idx),   32'(vecs[i].slot));
            chk($sformatf("vec%0d.tick",  i), 32'(frame_tick), 32'(vecs[i].tick));
        end

        // Digit change mid-DRIVE only shows at the next slot's BLANK entry.
        restart(8'h5A);
        step(); step();                       // t=2, slot 0 DRIVE
        digits_in = 8'h3C;
        for (int t = 3; t <= 7; t++) begin
            step();
            chk("chg.hold_hex", 32'(hex_sel), 32'hA);
        end
        step();                               // t=8, slot 1 BLANK
        chk("chg.new_hex", 32'(hex_sel), 32'h3);
        chk("chg.anode_blank", 32'(anode_n), 32'h3);
        for (int t = 9; t <= 12; t++) step(); // t=12, slot 1 DRIVE
        chk("chg.slot1_drive", 32'(anode_n), 32'h1);

        // Enable drop in slot 1 DRIVE, then re-enable.
        enable = 1'b0; step();
        chk("dis.anode", 32'(anode_n), 32'h3);
        chk("dis.slot", 32'(slot_idx), 32'h0);
        chk("dis.hex_hold", 32'(hex_sel), 32'h3);
        step();
        chk("idle.anode", 32'(anode_n), 32'h3);
        enable = 1'b1; step();
        chk("reen.anode", 32'(anode_n), 32'h3);
        chk("reen.slot", 32'(slot_idx), 32'h0);
        chk("reen.tick", 32'(frame_tick), 32'h0);
        chk("reen.hex", 32'(hex_sel), 32'hC);
        step(); step();
        chk("reen.drive", 32'(anode_n), 32'h2);

        // Reset mid-DRIVE with enable held high.
        reset = 1'b1; step();
        chk("rst.anode", 32'(anode_n), 32'h3);
        chk("rst.hex", 32'(hex_sel), 32'h0);
        chk("rst.slot", 32'(slot_idx), 32'h0);
        chk("rst.tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;

        // Four frames of free run: tick period and one-hot-low anode.
        restart(8'h5A);
        prev_hex = hex_sel;
        prev_anode = anode_n;
        for (int t = 1; t <= 4 * N * DIV; t++) begin
            step();
            chk("run.tick", 32'(frame_tick), 32'((t % (N * DIV)) == 0));
            chk("run.not_both", 32'(anode_n == 2'b00), 32'h0);
            if (prev_anode != 2'b11 && anode_n != 2'b11)
                chk("run.hex_stable", 32'(hex_sel), 32'(prev_hex));
            prev_hex = hex_sel;
            prev_anode = anode_n;
        end

`ifdef DISPLAY_LZ_BLANK_EN
        restart(8'h07);
        for (int t = 1; t < N * DIV; t++) begin
            step();
            chk("lz07.anode", 32'(anode_n),
                32'(((t % DIV) < BLANK || t >= DIV) ? 2'b11 : 2'b10));
        end
        restart(8'h00);
        step(); step();
        chk("lz00.anode", 32'(anode_n), 32'h2);
        chk("lz00.hex", 32'(hex_sel), 32'h0);
`endif

        // Randomised run against the reference model.
        reset = 1'b1; enable = 1'b0; step();
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom % 300) == 0;
            enable = ($urandom % 60) != 0;
            if (($urandom % 6) == 0)
                digits_in = {4'($urandom_range(0, 2) == 0 ? 0 : $urandom),
                             4'($urandom_range(0, 2) == 0 ? 0 : $urandom)};
            step();
            chk("rnd.anode", 32'(anode_n),    32'(m_anode));
            chk("rnd.hex",   32'(hex_sel),    32'(m_hex));
            chk("rnd.slot",  32'(slot_idx),   32'(m_slot));
            chk("rnd.tick",  32'(frame_tick), 32'(m_tick));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
